// File: rtl/ped_req_scheduler_pkg.sv
// Shared state encoding and default timing for the pedestrian request scheduler.
// The state values match the main_ltc bench encoding so traces line up across blocks.
package ped_req_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_SERVE    = 3'd3,
    S_HOLD     = 3'd4
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_IDW     = 2;
  localparam int DEF_MIN_GAP = 20000;
  localparam int DEF_ACK_TO  = 50;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/ped_req_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; any=0 means idx is meaningless.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDW-1:0]     off;
  logic [IDW:0]       sum;

  always_comb begin
    any = |req;
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    // Scan downwards so the lowest rotated position (closest to ptr) wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ) sum = sum - NREQ;
    idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/ped_req_scheduler.sv
// Latches button presses and issues them round-robin to main_ltc as one-cycle N pulses.
// Press to n_out is 2 cycles from IDLE; a minimum holdoff follows every pedestrian phase.
module ped_req_scheduler
  import ped_req_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = DEF_IDW,
  parameter int MIN_GAP = DEF_MIN_GAP,
  parameter int ACK_TO  = DEF_ACK_TO,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] btn,
  input  logic               ped_busy,
  output logic               n_out,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic [NUM_REQ-1:0] pend,
  output logic               fault
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] btn_q, btn_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               n_out_q, n_out_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               fault_q, fault_d;

  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] pend_clr;
  logic [CNT_W-1:0]   cnt_inc;
  logic               pick_any;
  logic [IDW-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_pick (
    .req(pend_q),
    .ptr(rr_ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  always_comb begin
    btn_d         = btn;
    rise          = btn & ~btn_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    n_out_d       = 1'b0;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    fault_d       = fault_q;
    pend_clr      = '0;
    cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      // The pick is committed on the edge into ISSUE so the pulse lands 2 cycles after the press.
      S_IDLE: begin
        if (pick_any) begin
          state_d       = S_ISSUE;
          n_out_d       = 1'b1;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx;
          pend_clr      = NUM_REQ'(1) << pick_idx;
          rr_ptr_d      = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + IDW'(1);
          cnt_d         = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ped_busy) begin
          state_d = S_SERVE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(ACK_TO - 1)) begin
            fault_d       = 1'b1;
            grant_valid_d = 1'b0;
            cnt_d         = '0;
            state_d       = S_HOLD;
          end
        end
      end
      S_SERVE: begin
        if (!ped_busy) begin
          grant_valid_d = 1'b0;
          cnt_d         = '0;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(MIN_GAP - 1)) state_d = S_IDLE;
        else                              cnt_d   = cnt_inc;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh press beats the issue-time clear of the same bit.
    pend_d = (pend_q & ~pend_clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      btn_q         <= '0;
      pend_q        <= '0;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      n_out_q       <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      n_out_q       <= n_out_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      fault_q       <= fault_d;
    end
  end

  assign n_out       = n_out_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign pend        = pend_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ped_req_scheduler.sv
// Directed bench for ped_req_scheduler: cycle table for reset and a single press,
// hand sequences for round robin, ack timeout, re-press and mid-phase reset.
module tb_ped_req_scheduler;
  import ped_req_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       ped_busy;
  logic       n_out;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] pend;
  logic       fault;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ped_req_scheduler #(
    .NUM_REQ(4),
    .IDW    (2),
    .MIN_GAP(10),
    .ACK_TO (5),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .ped_busy   (ped_busy),
    .n_out      (n_out),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .pend       (pend),
    .fault      (fault)
  );

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       busy;
    logic       n;
    logic       gv;
    logic [1:0] gid;
    logic [3:0] pend;
    logic       flt;
    state_e     st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] b, input logic bz,
                              input logic n, input logic gv, input logic [1:0] gid,
                              input logic [3:0] p, input logic f, input state_e s);
    vec_t v;
    v.rst = r; v.btn = b; v.busy = bz;
    v.n = n; v.gv = gv; v.gid = gid; v.pend = p; v.flt = f; v.st = s;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_nout(input string name);
    int n = 0;
    while (n_out !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check(name, n_out, 1);
  endtask

  task automatic wait_state(input state_e s, input string name);
    int n = 0;
    while (dut.state_q !== s && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(dut.state_q), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_exp [3];
    int last_fall;
    int k;
    int pulses;

    rst = 1'b1; btn = 4'hF; ped_busy = 1'b0;

    // Reset with buttons held, release, re-reset, then a single press of post 2.
    add(1, 4'hF, 0, 0, 0, 0, 4'h0, 0, S_IDLE);
    add(1, 4'hF, 0, 0, 0, 0, 4'h0, 0, S_IDLE);
    add(0, 4'hF, 0, 0, 0, 0, 4'hF, 0, S_IDLE);
    add(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, S_IDLE);
    add(0, 4'h0, 0, 0, 0, 0, 4'h0, 0, S_IDLE);
    add(0, 4'h4, 0, 0, 0, 0, 4'h4, 0, S_IDLE);
    add(0, 4'h4, 0, 1, 1, 2, 4'h0, 0, S_ISSUE);
    add(0, 4'h4, 0, 0, 1, 2, 4'h0, 0, S_WAIT_ACK);
    add(0, 4'h4, 0, 0, 1, 2, 4'h0, 0, S_WAIT_ACK);
    for (int i = 0; i < 8; i++) add(0, 4'h4, 1, 0, 1, 2, 4'h0, 0, S_SERVE);
    for (int i = 0; i < 10; i++) add(0, 4'h0, 0, 0, 0, 2, 4'h0, 0, S_HOLD);
    add(0, 4'h0, 0, 0, 0, 2, 4'h0, 0, S_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; btn = vecs[i].btn; ped_busy = vecs[i].busy;
      tick();
      check($sformatf("v%0d_n_out", i), n_out, vecs[i].n);
      check($sformatf("v%0d_grant_valid", i), grant_valid, vecs[i].gv);
      if (vecs[i].gv) check($sformatf("v%0d_grant_id", i), grant_id, vecs[i].gid);
      check($sformatf("v%0d_pend", i), pend, vecs[i].pend);
      check($sformatf("v%0d_fault", i), fault, vecs[i].flt);
      check($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(vecs[i].st));
    end

    // Round robin over 1011 from rr_ptr=0.
    rr_exp = '{2'd0, 2'd1, 2'd3};
    rst = 1'b1; btn = 4'h0; ped_busy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rr_ptr_start", dut.rr_ptr_q, 0);
    btn = 4'b1011;
    tick();
    check("rr_pend_latched", pend, 4'b1011);
    last_fall = 0;
    for (int g = 0; g < 3; g++) begin
      wait_nout($sformatf("rr%0d_n_out", g));
      check($sformatf("rr%0d_grant_id", g), grant_id, rr_exp[g]);
      if (g > 0) check($sformatf("rr%0d_gap", g), cyc - last_fall, 11);
      tick();
      tick();
      ped_busy = 1'b1;
      repeat (4) tick();
      check($sformatf("rr%0d_gv_serve", g), grant_valid, 1);
      ped_busy = 1'b0;
      tick();
      check($sformatf("rr%0d_gv_drop", g), grant_valid, 0);
      last_fall = cyc;
    end
    wait_state(S_IDLE, "rr_idle");
    check("rr_ptr_end", dut.rr_ptr_q, 0);
    check("rr_pend_end", pend, 0);

    // Ack timeout on post 1.
    btn = 4'h0;
    tick();
    btn = 4'b0010;
    wait_nout("to_n_out");
    check("to_grant_id", grant_id, 1);
    k = cyc;
    repeat (4) tick();
    check("to_fault_early", fault, 0);
    check("to_gv_early", grant_valid, 1);
    tick();
    check("to_delay", cyc - k, 5);
    check("to_fault", fault, 1);
    check("to_gv", grant_valid, 0);
    check("to_pend1", pend[1], 0);
    check("to_state_hold", 32'(dut.state_q), 32'(S_HOLD));
    repeat (9) tick();
    check("to_hold_last", 32'(dut.state_q), 32'(S_HOLD));
    tick();
    check("to_hold_done", 32'(dut.state_q), 32'(S_IDLE));

    // Re-press of post 0 during its own SERVE is kept and served next round.
    btn = 4'h0;
    tick();
    btn = 4'b0001;
    wait_nout("rp_n_out");
    check("rp_grant_id", grant_id, 0);
    btn = 4'h0;
    tick();
    ped_busy = 1'b1;
    tick();
    check("rp_state_serve", 32'(dut.state_q), 32'(S_SERVE));
    btn = 4'b0001;
    tick();
    check("rp_pend_in_serve", pend, 4'b0001);
    check("rp_gv_in_serve", grant_valid, 1);
    ped_busy = 1'b0;
    tick();
    check("rp_state_hold", 32'(dut.state_q), 32'(S_HOLD));
    check("rp_pend_in_hold", pend, 4'b0001);
    last_fall = cyc;
    wait_nout("rp_second_n_out");
    check("rp_second_gid", grant_id, 0);
    check("rp_second_gap", cyc - last_fall, 11);
    check("rp_pend_cleared", pend, 0);
    check("rp_fault_sticky", fault, 1);

    // Press landing on the same edge as the issue of that bit: set wins.
    btn = 4'h0;
    tick();
    ped_busy = 1'b1;
    tick();
    ped_busy = 1'b0;
    tick();
    btn = 4'b0001;
    tick();
    btn = 4'h0;
    tick();
    check("sw_pend_hold", pend, 4'b0001);
    wait_state(S_IDLE, "sw_idle");
    btn = 4'b0001;
    tick();
    check("sw_n_out", n_out, 1);
    check("sw_grant_id", grant_id, 0);
    check("sw_pend_kept", pend, 4'b0001);
    btn = 4'h0;
    wait_state(S_HOLD, "sw_hold");
    wait_nout("sw_again_n_out");
    check("sw_again_gid", grant_id, 0);
    wait_state(S_HOLD, "sw_again_hold");
    wait_state(S_IDLE, "sw_again_idle");

    // Reset during SERVE.
    btn = 4'b1000;
    wait_nout("rs_n_out");
    check("rs_grant_id", grant_id, 3);
    tick();
    ped_busy = 1'b1;
    tick();
    check("rs_state_serve", 32'(dut.state_q), 32'(S_SERVE));
    btn = 4'b1100;
    tick();
    check("rs_pend_before", pend, 4'b0100);
    rst = 1'b1; btn = 4'h0;
    tick();
    check("rs_state", 32'(dut.state_q), 32'(S_IDLE));
    check("rs_n_out", n_out, 0);
    check("rs_gv", grant_valid, 0);
    check("rs_pend", pend, 0);
    check("rs_fault", fault, 0);
    rst = 1'b0; ped_busy = 1'b0;
    pulses = 0;
    repeat (6) begin
      tick();
      if (n_out === 1'b1) pulses++;
    end
    check("rs_no_replay", pulses, 0);

    // Reset during HOLD after a timeout, with a request latched in HOLD.
    btn = 4'b0010;
    wait_nout("rh_n_out");
    wait_state(S_HOLD, "rh_hold");
    check("rh_fault_set", fault, 1);
    btn = 4'h0;
    tick();
    btn = 4'b0100;
    tick();
    check("rh_pend_before", pend, 4'b0100);
    rst = 1'b1; btn = 4'h0;
    tick();
    check("rh_state", 32'(dut.state_q), 32'(S_IDLE));
    check("rh_pend", pend, 0);
    check("rh_fault", fault, 0);
    check("rh_gv", grant_valid, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      tick();
      if (n_out === 1'b1) pulses++;
    end
    check("rh_no_replay", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
